// File: rtl/i2s_mic_array_rx_if.sv
// Sample-frame handshake between the mic array receiver and the xcorr consumer.
// DATA_W = NUM_LINES*2*OUT_W; each line packs {R, L} with L in the lower half.
interface i2s_mic_array_rx_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              smp_ready;
  logic              smp_ovr;

  modport master (output smp_data, output smp_valid, output smp_ovr, input smp_ready);
  modport slave  (input smp_data, input smp_valid, input smp_ovr, output smp_ready);
endinterface

// File: rtl/i2s_mic_array_rx.sv
// I2S master receiver: generates mic_clk/mic_ws and deserialises NUM_LINES stereo lines.
// Define MIC_RX_OVR_EN to drop frames that arrive while one is still pending (sticky smp_ovr).
module i2s_mic_array_rx #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_LINES = 4,
  parameter int SLOT_W    = 32,
  parameter int SAMPLE_W  = 24,
  parameter int OUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_LINES-1:0] mic_da,
  output logic                 mic_clk,
  output logic                 mic_ws,
  i2s_mic_array_rx_if.master   smp
);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W   = $clog2(2 * SLOT_W);
  localparam int FRAME_W = NUM_LINES * 2 * OUT_W;

  logic [DIV_W-1:0]   div_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   bit_cnt_next;
  logic [CNT_W-1:0]   slot_idx;
  logic               mic_clk_reg;
  logic               mic_ws_reg;
  logic               div_wrap;
  logic               sample_pt;
  logic               capture;
  logic               frame_done;
  logic               accept;
  logic [FRAME_W-1:0] frame_word;
  logic [FRAME_W-1:0] smp_data_reg;
  logic               smp_valid_reg;

  assign div_wrap     = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign sample_pt    = en & div_wrap & mic_clk_reg;
  assign bit_cnt_next = (bit_cnt_reg == CNT_W'(2 * SLOT_W - 1)) ? '0 : bit_cnt_reg + CNT_W'(1);
  assign slot_idx     = mic_ws_reg ? bit_cnt_reg - CNT_W'(SLOT_W) : bit_cnt_reg;
  // Only the OUT_W MSBs survive truncation, so later data bits need not be shifted in.
  assign capture      = sample_pt & (slot_idx != '0) & (slot_idx <= CNT_W'(OUT_W));
  assign frame_done   = sample_pt & mic_ws_reg & (slot_idx == CNT_W'(SAMPLE_W));
  assign accept       = smp_valid_reg & smp.smp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      mic_clk_reg <= 1'b0;
      mic_ws_reg  <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      mic_clk_reg <= 1'b0;
      mic_ws_reg  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_reg <= '0;
      mic_clk_reg <= ~mic_clk_reg;
      if (mic_clk_reg) begin
        bit_cnt_reg <= bit_cnt_next;
        mic_ws_reg  <= (bit_cnt_next >= CNT_W'(SLOT_W));
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic [OUT_W-1:0] sh_l_reg;
      logic [OUT_W-1:0] sh_r_reg;
      logic [OUT_W-1:0] r_word;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_l_reg <= '0;
          sh_r_reg <= '0;
        end else if (!en) begin
          sh_l_reg <= '0;
          sh_r_reg <= '0;
        end else if (capture) begin
          if (mic_ws_reg) sh_r_reg <= {sh_r_reg[OUT_W-2:0], mic_da[gi]};
          else            sh_l_reg <= {sh_l_reg[OUT_W-2:0], mic_da[gi]};
        end
      end

      // When every sample bit is kept, the last right bit arrives in the frame_done cycle.
      if (OUT_W == SAMPLE_W) begin : g_full
        assign r_word = {sh_r_reg[OUT_W-2:0], mic_da[gi]};
      end else begin : g_trunc
        assign r_word = sh_r_reg;
      end

      assign frame_word[gi*2*OUT_W +: 2*OUT_W] = {r_word, sh_l_reg};
    end
  endgenerate

`ifdef MIC_RX_OVR_EN
  logic smp_ovr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_data_reg  <= '0;
      smp_valid_reg <= 1'b0;
      smp_ovr_reg   <= 1'b0;
    end else if (frame_done && smp_valid_reg && !accept) begin
      smp_ovr_reg <= 1'b1;
    end else if (frame_done) begin
      smp_data_reg  <= frame_word;
      smp_valid_reg <= 1'b1;
    end else if (accept) begin
      smp_valid_reg <= 1'b0;
    end
  end

  assign smp.smp_ovr = smp_ovr_reg;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_data_reg  <= '0;
      smp_valid_reg <= 1'b0;
    end else if (frame_done) begin
      smp_data_reg  <= frame_word;
      smp_valid_reg <= 1'b1;
    end else if (accept) begin
      smp_valid_reg <= 1'b0;
    end
  end

  assign smp.smp_ovr = 1'b0;
`endif

  assign mic_clk       = mic_clk_reg;
  assign mic_ws        = mic_ws_reg;
  assign smp.smp_data  = smp_data_reg;
  assign smp.smp_valid = smp_valid_reg;
endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Directed bench for i2s_mic_array_rx: clk-level timing model plus a frame scoreboard.
// Follows MIC_RX_OVR_EN the same way the design build does.
module tb_i2s_mic_array_rx;
  localparam int CLK_DIV = 2;
  localparam int NL      = 4;
  localparam int SLOT_W  = 32;
  localparam int SW      = 24;
  localparam int OW      = 16;
  localparam int DW      = NL * 2 * OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [NL-1:0] mic_da = '0;
  logic          mic_clk;
  logic          mic_ws;

  i2s_mic_array_rx_if #(.DATA_W(DW)) smp ();

  i2s_mic_array_rx #(
    .CLK_DIV(CLK_DIV), .NUM_LINES(NL), .SLOT_W(SLOT_W), .SAMPLE_W(SW), .OUT_W(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mic_da(mic_da),
    .mic_clk(mic_clk), .mic_ws(mic_ws), .smp(smp.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [SW-1:0] tab_l [NL];
  logic [SW-1:0] tab_r [NL];
  logic [DW-1:0] sb_q [$];

  int   m_div = 0;
  int   m_bit = 0;
  logic m_sck = 1'b0;
  logic m_ws  = 1'b0;
  logic m_ovr = 1'b0;
  int   frames_done = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_frame();
    logic [DW-1:0] f;
    logic [SW-1:0] wl, wr;
    f = '0;
    for (int i = 0; i < NL; i++) begin
      wl = tab_l[i];
      wr = tab_r[i];
      f[2*i*OW +: OW]     = wl[SW-1 -: OW];
      f[(2*i+1)*OW +: OW] = wr[SW-1 -: OW];
    end
    return f;
  endfunction

  // Serial value presented by each mic for stream bit b (one-bit I2S delay, idle bits 1).
  function automatic logic [NL-1:0] da_for(input int b);
    logic [NL-1:0] v;
    logic [SW-1:0] w;
    int s;
    s = b % SLOT_W;
    v = '1;
    for (int i = 0; i < NL; i++) begin
      w = (b >= SLOT_W) ? tab_r[i] : tab_l[i];
      if (s >= 1 && s <= SW) v[i] = w[SW-s];
    end
    return v;
  endfunction

  function automatic void model_reset();
    m_div = 0; m_bit = 0; m_sck = 1'b0; m_ws = 1'b0;
  endfunction

  function automatic void set_tables(input logic [SW-1:0] l0, input logic [SW-1:0] ln,
                                     input logic [SW-1:0] r);
    for (int i = 0; i < NL; i++) begin
      tab_l[i] = (i == 0) ? l0 : ln;
      tab_r[i] = r;
    end
  endfunction

  // One clk: check outputs at negedge, drive mic_da, advance the model across the edge.
  task automatic tick();
    logic acc, done;
    chk("mic_clk", DW'(mic_clk), DW'(m_sck));
    chk("mic_ws", DW'(mic_ws), DW'(m_ws));
    chk("smp_valid", DW'(smp.smp_valid), DW'(sb_q.size() != 0));
    chk("smp_ovr", DW'(smp.smp_ovr), DW'(m_ovr));
    acc = (sb_q.size() != 0) && smp.smp_ready;
    if (acc) begin
      chk("smp_data", smp.smp_data, sb_q[0]);
      void'(sb_q.pop_front());
    end
    mic_da = da_for(m_bit);
    done = en && m_sck && (m_div == CLK_DIV - 1) && m_ws && ((m_bit % SLOT_W) == SW);
    if (!en) model_reset();
    else if (m_div == CLK_DIV - 1) begin
      m_div = 0;
      if (m_sck) begin
        m_bit = (m_bit + 1) % (2 * SLOT_W);
        m_ws  = (m_bit >= SLOT_W);
      end
      m_sck = !m_sck;
    end else m_div++;
    if (done) begin
      frames_done++;
      if (sb_q.size() != 0) begin
`ifdef MIC_RX_OVR_EN
        m_ovr = 1'b1;
`else
        sb_q[0] = exp_frame();
`endif
      end else sb_q.push_back(exp_frame());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_frame(input string tag);
    int start, k;
    start = frames_done;
    k = 0;
    while (frames_done == start && k < 600) begin
      tick();
      k++;
    end
    chk({tag, "_frame_seen"}, DW'(frames_done > start), DW'(1));
  endtask

  task automatic run_until_bit(input string tag, input int b);
    int k;
    k = 0;
    while (m_bit != b && k < 600) begin
      tick();
      k++;
    end
    chk({tag, "_bit_reached"}, DW'(m_bit), DW'(b));
  endtask

  initial begin
    smp.smp_ready = 1'b0;
    set_tables('1, '1, '1);
    repeat (3) @(negedge clk);
    chk("rst_mic_clk", DW'(mic_clk), '0);
    chk("rst_mic_ws", DW'(mic_ws), '0);
    chk("rst_smp_data", smp.smp_data, '0);
    chk("rst_smp_valid", DW'(smp.smp_valid), '0);
    chk("rst_smp_ovr", DW'(smp.smp_ovr), '0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic frame, clock start-up timing and data alignment.
    set_tables(24'hA5C3F0, 24'hA5C3F0, 24'h123456);
    smp.smp_ready = 1'b1;
    en = 1'b1;
    tick();
    chk("first_rise_clk1", DW'(mic_clk), '0);
    tick();
    chk("first_rise_clk2", DW'(mic_clk), DW'(1));
    run_until_frame("pattern_a5c3");
    chk("frame_a5c3_value", sb_q[0], {NL{16'h1234, 16'hA5C3}});
    tick();

    // Sign boundary values.
    set_tables(24'h800000, 24'h7FFFFF, 24'h000000);
    run_until_frame("pattern_sign");
    chk("frame_sign_value", sb_q[0], {{3{16'h0000, 16'h7FFF}}, 16'h0000, 16'h8000});
    tick();

    // Two frames without acceptance.
    smp.smp_ready = 1'b0;
    set_tables(24'h111111, 24'h222222, 24'h333333);
    run_until_frame("ovr_first");
    set_tables(24'hCAFE00, 24'hBEEF00, 24'h5A5A5A);
    run_until_frame("ovr_second");
    repeat (4) tick();
`ifdef MIC_RX_OVR_EN
    chk("ovr_flag", DW'(smp.smp_ovr), DW'(1));
    chk("ovr_held", smp.smp_data, {{3{16'h3333, 16'h2222}}, 16'h3333, 16'h1111});
`else
    chk("ovr_flag", DW'(smp.smp_ovr), '0);
    chk("ovr_held", smp.smp_data, {{3{16'h5A5A, 16'hBEEF}}, 16'h5A5A, 16'hCAFE});
`endif
    smp.smp_ready = 1'b1;
    repeat (2) tick();

    // en dropped mid right slot, then restarted.
    set_tables(24'h0F0F0F, 24'hF0F0F0, 24'h3C3C3C);
    run_until_bit("en_drop", 40);
    en = 1'b0;
    tick();
    chk("en_drop_mic_clk", DW'(mic_clk), '0);
    chk("en_drop_mic_ws", DW'(mic_ws), '0);
    repeat (99) tick();
    en = 1'b1;
    run_until_frame("en_restart");
    tick();

    // Async reset while a frame is pending.
    smp.smp_ready = 1'b0;
    set_tables(24'h13579B, 24'h2468AC, 24'hFEDCBA);
    run_until_frame("rst_pending");
    run_until_bit("rst_mid", 40);
    chk("rst_pre_valid", DW'(smp.smp_valid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mic_clk", DW'(mic_clk), '0);
    chk("arst_mic_ws", DW'(mic_ws), '0);
    chk("arst_smp_data", smp.smp_data, '0);
    chk("arst_smp_valid", DW'(smp.smp_valid), '0);
    chk("arst_smp_ovr", DW'(smp.smp_ovr), '0);
    model_reset();
    sb_q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    smp.smp_ready = 1'b1;
    set_tables(24'h765432, 24'h89ABCD, 24'h0C0FFE);
    run_until_frame("post_rst");
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
